// File: rtl/timer_pkg.sv
// Shared constants and types for the stopwatch timer and its display consumers.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package timer_pkg;

    localparam int unsigned MS_MAX   = 999_999;
    localparam int unsigned N_DIGITS = 6;
    localparam int unsigned DP_DIGIT = 3;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_e;

    // Codes 10..15 cannot occur after clamping; they fall to all-off.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential 20-bit binary to 6-digit BCD converter (shift-add-3).
// One sample, 20 shift steps, one load: a new result every 22 cycles.
module bin2bcd_seq
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        KEY2,
    input  logic [19:0] bin,
    output logic [23:0] bcd,
    output logic        bcd_valid
);

    conv_state_e state_q, state_d;
    logic [43:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic [43:0] adj;
    logic [19:0] bin_clamped;

    assign bin_clamped = (bin > 20'(MS_MAX)) ? 20'(MS_MAX) : bin;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        adj     = sr_q;
        case (state_q)
            ST_IDLE: begin
                sr_d    = {24'd0, bin_clamped};
                cnt_d   = 5'd19;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                for (int i = 0; i < 6; i++) begin
                    if (adj[20 + 4 * i +: 4] >= 4'd5) begin
                        adj[20 + 4 * i +: 4] = adj[20 + 4 * i +: 4] + 4'd3;
                    end
                end
                sr_d = {adj[42:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_LOAD: begin
                bcd_d   = sr_q[43:20];
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge KEY2) begin
        if (!KEY2) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: rtl/t_display_scan.sv
// Stopwatch display: converts the ms count to BCD and scans it onto a six-digit
// multiplexed seven-segment display as SSS.mmm.
module t_display_scan
    import timer_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50_000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        KEY2,
    input  logic [19:0] t,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig,
    output logic [23:0] bcd,
    output logic        bcd_valid
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [23:0]   bcd_w;
    logic          bcd_valid_w;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    dig_q, dig_d;
    logic [3:0]    nib;
    logic          blank;

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .KEY2      (KEY2),
        .bin       (t),
        .bcd       (bcd_w),
        .bcd_valid (bcd_valid_w)
    );

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == 3'(N_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    nib = bcd_w[3:0];
            3'd1:    nib = bcd_w[7:4];
            3'd2:    nib = bcd_w[11:8];
            3'd3:    nib = bcd_w[15:12];
            3'd4:    nib = bcd_w[19:16];
            3'd5:    nib = bcd_w[23:20];
            default: nib = 4'hF;
        endcase
    end

    // Only the two hundreds/tens-of-seconds digits are ever blanked.
    assign blank = BLANK_LZ && (((idx_q == 3'd5) && (bcd_w[23:20] == 4'd0)) ||
                                ((idx_q == 3'd4) && (bcd_w[23:16] == 8'd0)));

    always_comb begin
        seg_d = blank ? SEG_OFF : seg_decode(nib);
        dig_d = ~(6'b000001 << idx_q);
        dp_d  = ~(idx_q == 3'(DP_DIGIT));
    end

    always_ff @(posedge clk or negedge KEY2) begin
        if (!KEY2) begin
            pre_q <= '0;
            idx_q <= 3'd0;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            dig_q <= 6'h3F;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            dig_q <= dig_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign dig       = dig_q;
    assign bcd       = bcd_w;
    assign bcd_valid = bcd_valid_w;

endmodule

// File: tb/tb_t_display_scan.sv
// Scoreboard bench for t_display_scan: conversions are queued with their due edge
// and checked by a monitor; display frames are checked cycle by cycle.
module tb_t_display_scan;

    logic        clk;
    logic        KEY2;
    logic [19:0] t;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [5:0]  dig0, dig1;
    logic [23:0] bcd0, bcd1;
    logic        v0, v1;

    typedef struct {
        logic [23:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass;
    int   n_total;
    int   cyc;
    int   last_v;

    t_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .KEY2(KEY2), .t(t), .seg(seg0), .dp(dp0), .dig(dig0),
        .bcd(bcd0), .bcd_valid(v0)
    );

    t_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .KEY2(KEY2), .t(t), .seg(seg1), .dp(dp1), .dig(dig1),
        .bcd(bcd1), .bcd_valid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: every conversion result that has an expectation queued is checked
    // for value and for the edge it arrived on.
    initial last_v = 0;
    always @(negedge clk) begin
        if (KEY2 && v0) begin
            last_v = cyc;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("bcd_value", {8'd0, bcd0}, {8'd0, mon_e.val});
                chk("bcd_latency", cyc, mon_e.due);
                chk("bcd_match_lz", {8'd0, bcd1}, {8'd0, bcd0});
            end
        end
    end

    // Called between a negedge and the next posedge, which is the sample edge.
    task automatic push(input logic [23:0] v);
        exp_t e;
        e.val = v;
        e.due = cyc + 22;
        sb.push_back(e);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v0 && n < 100);
        if (!v0) timeout("wait_valid");
    endtask

    task automatic apply(input logic [19:0] tv, input logic [23:0] exp);
        wait_valid();
        #1;
        t = tv;
        push(exp);
    endtask

    function automatic logic [5:0] rd_dig(input bit sel);
        return sel ? dig1 : dig0;
    endfunction

    function automatic logic [6:0] rd_seg(input bit sel);
        return sel ? seg1 : seg0;
    endfunction

    function automatic logic rd_dp(input bit sel);
        return sel ? dp1 : dp0;
    endfunction

    // exp holds the seg code for digit k at [7k +: 7].
    task automatic check_frame(input bit sel, input logic [41:0] exp);
        logic [5:0] prev, cur;
        logic       found;
        int         n;
        prev  = rd_dig(sel);
        found = 1'b0;
        n     = 0;
        do begin
            @(negedge clk);
            cur   = rd_dig(sel);
            found = (cur == 6'h3E) && (prev == 6'h1F);
            prev  = cur;
            n++;
        end while (!found && n < 200);
        if (!found) begin
            timeout("frame_sync");
        end else begin
            for (int k = 0; k < 6; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    chk("dig", {26'd0, rd_dig(sel)}, {26'd0, ~(6'b000001 << k)});
                    chk("seg", {25'd0, rd_seg(sel)}, {25'd0, exp[7*k +: 7]});
                    chk("dp", {31'd0, rd_dp(sel)}, (k == 3) ? 32'd0 : 32'd1);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dig"}, {26'd0, dig0}, 32'h3F);
        chk({tag, "_seg"}, {25'd0, seg0}, 32'h7F);
        chk({tag, "_dp"}, {31'd0, dp0}, 32'd1);
        chk({tag, "_bcd"}, {8'd0, bcd0}, 32'd0);
        chk({tag, "_valid"}, {31'd0, v0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [23:0] b;
        n_pass  = 0;
        n_total = 0;
        KEY2    = 1'b0;
        t       = 20'd0;

        @(negedge clk);
        check_reset_outputs("reset");
        #1;
        KEY2 = 1'b1;
        push(24'h000000);
        @(posedge clk);
        #1;
        chk("first_dig", {26'd0, dig0}, 32'h3E);
        chk("first_seg", {25'd0, seg0}, 32'h40);
        chk("first_dp", {31'd0, dp0}, 32'd1);
        check_frame(1'b0, {6{7'h40}});

        apply(20'd123_456, 24'h123456);
        wait_valid();
        check_frame(1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        apply(20'hFFFFF, 24'h999999);
        wait_valid();
        b = bcd0;
        for (int i = 0; i < 6; i++) begin
            chk("nibble_legal", {28'd0, b[4*i +: 4]}, 32'd9);
        end
        check_frame(1'b0, {6{7'h10}});

        // Input change three edges into SHIFT must not disturb the running conversion.
        apply(20'd5, 24'h000005);
        repeat (4) @(negedge clk);
        t = 20'd777_000;
        wait_valid();
        #1;
        push(24'h777000);
        wait_valid();
        chk("after_change", {8'd0, bcd0}, 32'h777000);

        apply(20'd4_321, 24'h004321);
        wait_valid();
        check_frame(1'b1, {7'h7F, 7'h7F, 7'h19, 7'h30, 7'h24, 7'h79});

        apply(20'd54_321, 24'h054321);
        wait_valid();
        check_frame(1'b1, {7'h7F, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});

        // Reset pulse mid-SHIFT while digit 3 is lit.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dig0 == 6'h37 && (cyc - last_v) >= 4 && (cyc - last_v) <= 15) &&
                   n < 2000);
        if (n >= 2000) timeout("reset_window");
        #1;
        KEY2 = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #1;
        KEY2 = 1'b1;
        push(24'h054321);
        @(posedge clk);
        #1;
        chk("restart_dig", {26'd0, dig0}, 32'h3E);
        chk("restart_seg", {25'd0, seg0}, 32'h40);
        wait_valid();
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
